pipe_addsub: RTL and testbench

- Parametrised, pipelined successor to the n-bit adder: WIDTH-bit add/subtract, carry chain split into STAGES registered chunks.
- Valid/ready handshake on input and output; one result per cycle when not stalled.
- Flags: unsigned carry/no-borrow and signed overflow.
- Sits between operand sources and result consumers in the datapath; the handshake lets it tolerate consumer back-pressure.

---
 rtl/pipe_addsub.sv | 126 ++++++++++++
 tb/tb_pipe_addsub.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, carry chain split into STAGES chunks.
// Optional PIPE_ADDSUB_SAT_EN clamps overflowing results to the signed limit.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             ov_q;
  logic             ov_d;

  logic             v_src [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];

  logic             adv;
  logic [CW:0]      t;

  // Stage k consumes the register of stage k-1; stage 0 takes the ports.
  always_comb begin
    v_src[0] = in_valid;
    a_src[0] = A;
    b_src[0] = sub ? ~B : B;
    s_src[0] = '0;
    c_src[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
    end
  end

  always_comb begin
    adv  = !v_q[L] || out_ready;
    t    = '0;
    ov_d = ov_q;
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = v_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
    end
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        t = {1'b0, a_src[k][k*CW +: CW]}
          + {1'b0, b_src[k][k*CW +: CW]}
          + {{CW{1'b0}}, c_src[k]};
        v_d[k] = v_src[k];
        a_d[k] = a_src[k];
        b_d[k] = b_src[k];
        s_d[k] = s_src[k];
        s_d[k][k*CW +: CW] = t[CW-1:0];
        c_d[k] = t[CW];
      end
      ov_d = (a_src[L][WIDTH-1] == b_src[L][WIDTH-1])
          && (s_d[L][WIDTH-1] != a_src[L][WIDTH-1]);
`ifdef PIPE_ADDSUB_SAT_EN
      if (ov_d) begin
        s_d[L] = a_src[L][WIDTH-1]
               ? {1'b1, {(WIDTH-1){1'b0}}}
               : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      ov_q <= ov_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[L];
  assign out       = s_q[L];
  assign carry     = c_q[L];
  assign overflow  = ov_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and random checks of pipe_addsub (STAGES 4, 1 and 32).
// Honours PIPE_ADDSUB_SAT_EN for the saturating build.
module tb_pipe_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] A, B;
  logic        sub;
  logic        out_valid, out_ready;
  logic [31:0] out;
  logic        carry, overflow;

  logic        rv, rs, r_rdy;
  logic [31:0] ra, rb;
  logic        u1_ir, u1_ov_v, u1_c, u1_ov;
  logic [31:0] u1_out;
  logic        u32_ir, u32_ov_v, u32_c, u32_ov;
  logic [31:0] u32_out;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry(carry), .overflow(overflow)
  );

  pipe_addsub #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(rv), .in_ready(u1_ir),
    .A(ra), .B(rb), .sub(rs),
    .out_valid(u1_ov_v), .out_ready(r_rdy),
    .out(u1_out), .carry(u1_c), .overflow(u1_ov)
  );

  pipe_addsub #(.WIDTH(32), .STAGES(32)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(rv), .in_ready(u32_ir),
    .A(ra), .B(rb), .sub(rs),
    .out_valid(u32_ov_v), .out_ready(r_rdy),
    .out(u32_out), .carry(u32_c), .overflow(u32_ov)
  );

`ifdef PIPE_ADDSUB_SAT_EN
  localparam logic [31:0] POS_OV = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OV = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OV = 32'h8000_0000;
  localparam logic [31:0] NEG_OV = 32'h7FFF_FFFF;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {32'd0, s};
    ov = (a[31] == be[31]) && (r[31] != a[31]);
`ifdef PIPE_ADDSUB_SAT_EN
    if (ov) r[31:0] = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ov, r[32], r[31:0]};
  endfunction

  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eo,
                         input logic ec, input logic eov,
                         input string tag);
    int lat;
    A = a; B = b; sub = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " out"}, 64'(out), 64'(eo));
    chk({tag, " carry"}, 64'(carry), 64'(ec));
    chk({tag, " ovf"}, 64'(overflow), 64'(eov));
    step();
  endtask

  localparam int N = 200;
  logic [33:0] exq [N];

  initial begin
    int sent, recv, stray;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; sub = 1'b0;
    rv = 1'b0; rs = 1'b0; ra = '0; rb = '0; r_rdy = 1'b1;
    repeat (2) step();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out", 64'(out), 64'd0);
    chk("rst carry", 64'(carry), 64'd0);
    chk("rst ovf", 64'(overflow), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step();

    run_one(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, "add10_20");
    run_one(32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, "wrap");
    run_one(32'd100, 32'd200, 1'b1, 32'hFFFF_FF9C, 1'b0, 1'b0, "sub_neg");
    run_one(32'h7FFF_FFFF, 32'd1, 1'b0, POS_OV, 1'b0, 1'b1, "pos_ovf");
    run_one(32'h8000_0000, 32'd1, 1'b1, NEG_OV, 1'b1, 1'b1, "neg_ovf");
    run_one(32'd50, 32'd50, 1'b1, 32'd0, 1'b1, 1'b0, "sub_eq");

    // Stream with consumer stall in cycles 5..7
    sent = 0; recv = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      in_valid = (sent < 8);
      A = 32'(sent); B = 32'(sent); sub = 1'b0;
      out_ready = !(c >= 5 && c <= 7);
      #2;
      if (c >= 5 && c <= 7) chk("stall in_ready", 64'(in_ready), 64'd0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("stream out", 64'(out), 64'(2 * recv));
        recv++;
      end
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream recv", 64'(recv), 64'd8);
    chk("stream sent", 64'(sent), 64'd8);
    step();

    // Async reset with three results in flight
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      A = (j == 0) ? 32'h7FFF_FFFF : 32'(j);
      B = 32'd1; sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("pre-rst valid", 64'(out_valid), 64'd1);
    chk("pre-rst ovf", 64'(overflow), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async valid", 64'(out_valid), 64'd0);
    chk("async out", 64'(out), 64'd0);
    chk("async carry", 64'(carry), 64'd0);
    chk("async ovf", 64'(overflow), 64'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    repeat (8) begin
      step();
      if (out_valid) stray++;
    end
    chk("no stale", 64'(stray), 64'd0);
    run_one(32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, "post_rst");

    // Random streams through STAGES=1 and STAGES=32
    for (int e = 0; e < N + 32; e++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rv = (e < N);
      if (e < N) exq[e] = model(ra, rb, rs);
      step();
      chk("s1 valid", 64'(u1_ov_v), 64'(e < N));
      if (e < N)
        chk("s1 result", 64'({u1_ov, u1_c, u1_out}), 64'(exq[e]));
      chk("s32 valid", 64'(u32_ov_v), 64'(e >= 31 && e - 31 < N));
      if (e >= 31 && e - 31 < N)
        chk("s32 result", 64'({u32_ov, u32_c, u32_out}), 64'(exq[e-31]));
    end
    rv = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
